// File: rtl/seq_karatsuba_mult.sv
// Sequential N x N unsigned multiplier using one-level Karatsuba on a single shared (N/2+1)-bit multiplier.
// Optional macro KARATSUBA_ZERO_BYPASS_EN: a zero operand skips the partial products and completes in one edge.
module seq_karatsuba_mult #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   X,
    input  logic [N-1:0]   Y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] Z
);
    localparam int H = N / 2;
    localparam int M = H + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P0   = 3'd1,
        P2   = 3'd2,
        P1   = 3'd3,
        COMB = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   x_q, x_d;
    logic [N-1:0]   y_q, y_d;
    logic [N-1:0]   z0_q, z0_d;
    logic [N-1:0]   z2_q, z2_d;
    logic [N+1:0]   z1_q, z1_d;
    logic [2*N-1:0] z_q, z_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;

    logic [M-1:0]   mul_a, mul_b;
    logic [2*M-1:0] mul_p;
    logic [2*N-1:0] mid_w;
    logic [2*N-1:0] z_comb;

    // The one multiplier: operands are steered by state so P0, P2 and P1 share it.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            P0: begin
                mul_a = {1'b0, x_q[H-1:0]};
                mul_b = {1'b0, y_q[H-1:0]};
            end
            P2: begin
                mul_a = {1'b0, x_q[N-1:H]};
                mul_b = {1'b0, y_q[N-1:H]};
            end
            P1: begin
                mul_a = {1'b0, x_q[H-1:0]} + {1'b0, x_q[N-1:H]};
                mul_b = {1'b0, y_q[H-1:0]} + {1'b0, y_q[N-1:H]};
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
        mul_p = {{M{1'b0}}, mul_a} * {{M{1'b0}}, mul_b};
    end

    // z1 >= z0 + z2 always, so the middle term never wraps at full width.
    always_comb begin
        mid_w  = {{(N-2){1'b0}}, z1_q} - {{N{1'b0}}, z2_q} - {{N{1'b0}}, z0_q};
        z_comb = {z2_q, {N{1'b0}}} + (mid_w << H) + {{N{1'b0}}, z0_q};
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z0_d        = z0_q;
        z2_d        = z2_q;
        z1_d        = z1_q;
        z_d         = z_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d        = X;
                    y_d        = Y;
                    in_ready_d = 1'b0;
`ifdef KARATSUBA_ZERO_BYPASS_EN
                    if ((X == '0) || (Y == '0)) begin
                        state_d     = DONE;
                        z_d         = '0;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = P0;
                    end
`else
                    state_d = P0;
`endif
                end
            end
            P0: begin
                z0_d    = mul_p[N-1:0];
                state_d = P2;
            end
            P2: begin
                z2_d    = mul_p[N-1:0];
                state_d = P1;
            end
            P1: begin
                z1_d    = mul_p;
                state_d = COMB;
            end
            COMB: begin
                z_d         = z_comb;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z0_q        <= '0;
            z2_q        <= '0;
            z1_q        <= '0;
            z_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z0_q        <= z0_d;
            z2_q        <= z2_d;
            z1_q        <= z1_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Z         = z_q;

endmodule
